student_logic_acc: RTL and testbench

//  Parametrised successor to the 1-bit AND gate: WIDTH-bit registered logic unit.
//  - Ops: AND, OR, XOR, NAND.
//  - Per-beat mode or burst-accumulate mode, which folds a burst of words into one result.
//  - valid/ready handshake on input and output.
//  - Sits between the operand source and the ALU result bus in the student datapath.

---
 rtl/student_logic_pkg.sv | 27 ++
 rtl/student_logic_op.sv | 26 ++
 rtl/student_logic_acc.sv | 167 ++++++++++++++++
 tb/tb_student_logic_acc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/student_logic_pkg.sv
// student_logic_pkg
//   Shared types and helpers for the student logic accumulator.
//   - op_e    : 2-bit operation code (AND, OR, XOR, NAND)
//   - state_e : accumulator FSM state (IDLE, ACCUM)
//   - base_op : maps an op to the bitwise op actually folded into the
//               accumulator (NAND folds as AND and is inverted at emit)
package student_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Inverting NAND on every fold would not be associative, so the burst
  // folds with AND and the single inversion happens on the emitted word.
  function automatic op_e base_op(input op_e o);
    return (o == OP_NAND) ? OP_AND : o;
  endfunction

endpackage

// File: rtl/student_logic_op.sv
// student_logic_op
//   Combinational WIDTH-bit base logic operation, z = base_op(op)(x, y).
//   Ports:
//     x, y : input  [WIDTH-1:0] operands
//     op   : input  op_e        requested op (NAND is evaluated as AND)
//     z    : output [WIDTH-1:0] result
module student_logic_op
  import student_logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  op_e              op,
  output logic [WIDTH-1:0] z
);

  always_comb begin
    case (base_op(op))
      OP_OR:   z = x | y;
      OP_XOR:  z = x ^ y;
      default: z = x & y;
    endcase
  end

endmodule

// File: rtl/student_logic_acc.sv
// student_logic_acc
//   WIDTH-bit registered logic unit with per-beat and burst-accumulate modes.
//   A beat in IDLE with acc_mode=0 produces f(a,b) directly; with acc_mode=1
//   it opens a burst that folds later beats' a into the accumulator until
//   in_last or MAX_BURST beats, then emits one result.
//
//   Optional feature macro: LOGIC_FLAGS_EN adds out_zero / out_msb.
//
//   Ports:
//     clk, rst_n        : clock (rising edge), async active-low reset
//     in_valid/in_ready : input beat handshake
//     a, b              : operands (b only used on the first beat of a burst)
//     op                : 00 AND, 01 OR, 10 XOR, 11 NAND
//     acc_mode          : 1 = beat opens an accumulate burst (IDLE only)
//     in_last           : closing beat of a burst
//     out, out_count    : result and number of beats folded into it
//     out_valid/out_ready : result handshake
//     out_zero, out_msb : (LOGIC_FLAGS_EN) out==0 and out[WIDTH-1]
//     dbg_state         : current FSM state, for observation only
//
//   Handshake: a beat transfers on a cycle where in_valid & in_ready, a result
//   transfers on a cycle where out_valid & out_ready. in_ready is
//   !out_valid | out_ready, so a new result can only be written when the slot
//   is empty or being drained in the same cycle; a held result (out_valid &
//   !out_ready) therefore never changes.
module student_logic_acc
  import student_logic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 255,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_FLAGS_EN
  output logic             out_zero,
  output logic             out_msb,
`endif
  output state_e           dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_BURST);
  localparam logic             SINGLE_BEAT = 1'(MAX_BURST == 1);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  op_e              in_op;
  op_e              cur_op;
  logic             accept;
  logic [WIDTH-1:0] opnd_x;
  logic [WIDTH-1:0] opnd_y;
  logic [WIDTH-1:0] base_z;
  logic [WIDTH-1:0] emit_val;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] emit_cnt;
  logic             emit;

  assign in_op     = op_e'(op);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // In IDLE the beat's own operands and op are used; inside a burst the
  // accumulator is folded with a under the op latched when the burst opened.
  always_comb begin
    if (state == ACCUM) begin
      opnd_x = acc;
      opnd_y = a;
      cur_op = op_q;
    end else begin
      opnd_x = a;
      opnd_y = b;
      cur_op = in_op;
    end
  end

  student_logic_op #(
    .WIDTH(WIDTH)
  ) u_op (
    .x  (opnd_x),
    .y  (opnd_y),
    .op (cur_op),
    .z  (base_z)
  );

  assign cnt_inc  = cnt + CNT_ONE;
  assign emit_val = (cur_op == OP_NAND) ? ~base_z : base_z;

  // Whether the accepted beat closes a result, and how many beats it holds.
  // In ACCUM cnt <= MAX_BURST-1, so cnt_inc cannot wrap.
  always_comb begin
    emit     = 1'b0;
    emit_cnt = CNT_ONE;
    if (accept) begin
      if (state == IDLE) begin
        emit = !acc_mode || in_last || SINGLE_BEAT;
      end else begin
        emit     = in_last || (cnt_inc == MAX_CNT);
        emit_cnt = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_AND;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
`ifdef LOGIC_FLAGS_EN
      out_zero  <= 1'b0;
      out_msb   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        case (state)
          IDLE: begin
            if (acc_mode) begin
              acc  <= base_z;
              op_q <= in_op;
              cnt  <= CNT_ONE;
              if (!(in_last || SINGLE_BEAT)) state <= ACCUM;
            end
          end
          ACCUM: begin
            acc <= base_z;
            cnt <= cnt_inc;
            if (emit) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // A new result may overwrite one that is handed off in this same cycle.
      if (emit) begin
        out       <= emit_val;
        out_count <= emit_cnt;
        out_valid <= 1'b1;
`ifdef LOGIC_FLAGS_EN
        out_zero  <= (emit_val == '0);
        out_msb   <= emit_val[WIDTH-1];
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_student_logic_acc.sv
module tb_student_logic_acc;
  import student_logic_pkg::*;

  localparam int W     = 4;
  localparam int MB    = 4;
  localparam int CW    = 3;
  localparam int LIMIT = 50;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          acc_mode;
  logic          in_last;
  logic [W-1:0]  out;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;
`ifdef LOGIC_FLAGS_EN
  logic          out_zero;
  logic          out_msb;
`endif
  state_e        dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [CW+W-1:0] exp_q[$];

  student_logic_acc #(
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .in_last   (in_last),
    .out       (out),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_FLAGS_EN
    .out_zero  (out_zero),
    .out_msb   (out_msb),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic push_exp(input int cnt, input logic [W-1:0] val);
    exp_q.push_back({CW'(cnt), val});
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                      input logic tacc, input logic tlast);
    int n;
    a = ta; b = tb; op = top; acc_mode = tacc; in_last = tlast;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    chk("accept_wait", 32'(n < LIMIT), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: every handoff pops and compares the oldest expected result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_result", 32'({out_count, out}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   rop;
    logic [W-1:0] racc;
    int           rlen;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
    acc_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_count", 32'(out_count), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. per-beat AND then NAND
    push_exp(1, 4'b1000);
    beat(4'b1100, 4'b1010, 2'b00, 1'b0, 1'b0);
    chk("pb_and_out", 32'(out), 32'b1000);
    chk("pb_and_count", 32'(out_count), 32'd1);
    chk("pb_and_valid", 32'(out_valid), 32'd1);
    push_exp(1, 4'b0111);
    beat(4'b1100, 4'b1010, 2'b11, 1'b0, 1'b1);
    chk("pb_nand_out", 32'(out), 32'b0111);
    chk("pb_nand_state", 32'(dbg_state), 32'(IDLE));

    // 2. backpressure: hold for 3 cycles, then handoff and accept in one cycle
    push_exp(1, 4'b0110);
    beat(4'b1100, 4'b1010, 2'b10, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_out", 32'({out_valid, out_count, out}), 32'({1'b1, 3'd1, 4'b0110}));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    push_exp(1, 4'b1110);
    beat(4'b1100, 4'b1010, 2'b01, 1'b0, 1'b0);
    chk("bp_next_out", 32'({out_valid, out}), 32'({1'b1, 4'b1110}));

    // 3. XOR burst of three
    push_exp(3, 4'b1000);
    beat(4'b0011, 4'b0101, 2'b10, 1'b1, 1'b0);
    chk("xor_no_valid_1", 32'(out_valid), 32'd0);
    chk("xor_state_accum", 32'(dbg_state), 32'(ACCUM));
    beat(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
    chk("xor_no_valid_2", 32'(out_valid), 32'd0);
    beat(4'b0001, 4'b1111, 2'b01, 1'b1, 1'b1);
    chk("xor_result", 32'({out_valid, out_count, out}), 32'({1'b1, 3'd3, 4'b1000}));

    // 4. NAND burst of two
    push_exp(2, 4'b1001);
    beat(4'b1111, 4'b1110, 2'b11, 1'b1, 1'b0);
    beat(4'b0111, 4'b0000, 2'b10, 1'b0, 1'b1);
    chk("nand_result", 32'({out_count, out}), 32'({3'd2, 4'b1001}));

    // 5. overflow: four OR beats force-emit, fifth opens a new burst
    push_exp(4, 4'b0111);
    beat(4'b0001, 4'b0000, 2'b01, 1'b1, 1'b0);
    beat(4'b0010, 4'b0000, 2'b01, 1'b1, 1'b0);
    beat(4'b0100, 4'b0000, 2'b01, 1'b1, 1'b0);
    chk("ovf_no_valid", 32'(out_valid), 32'd0);
    beat(4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0);
    chk("ovf_forced", 32'({out_valid, out_count, out}), 32'({1'b1, 3'd4, 4'b0111}));
    chk("ovf_state_idle", 32'(dbg_state), 32'(IDLE));
    push_exp(1, 4'b1000);
    beat(4'b1000, 4'b0000, 2'b01, 1'b1, 1'b1);
    chk("ovf_new_burst", 32'({out_count, out}), 32'({3'd1, 4'b1000}));
`ifdef LOGIC_FLAGS_EN
    chk("flag_msb_set", 32'({out_zero, out_msb}), 32'b01);
`endif

    // random per-beat stream at full rate
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      push_exp(1, model(rop, ra, rb));
      beat(ra, rb, rop, 1'b0, 1'($urandom_range(0, 1)));
    end

    // random XOR burst of 2..4 beats
    rlen = $urandom_range(1, 3);
    ra = W'($urandom_range(0, 15));
    rb = W'($urandom_range(0, 15));
    racc = ra ^ rb;
    for (int i = 0; i < rlen; i++) begin
      ra = W'($urandom_range(0, 15));
      racc = racc ^ ra;
    end
    push_exp(rlen + 1, racc);
    beat(racc ^ rb, rb, 2'b10, 1'b1, 1'b0);
    ra = '0;
    for (int i = 0; i < rlen; i++) beat(4'b0000, 4'b0000, 2'b00, 1'b0, 1'(i == rlen - 1));
    chk("rand_burst", 32'({out_valid, out_count, out}), 32'({1'b1, CW'(rlen + 1), racc}));

    // 6. reset in the middle of a burst
    @(posedge clk);
    #1;
    beat(4'b0101, 4'b0011, 2'b00, 1'b1, 1'b0);
    beat(4'b0111, 4'b0000, 2'b00, 1'b0, 1'b0);
    beat(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
    chk("rst_pre_state", 32'(dbg_state), 32'(ACCUM));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({out_valid, out_count, out}), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(1, 4'b0000);
    beat(4'b1010, 4'b1010, 2'b10, 1'b0, 1'b0);
    chk("post_rst_out", 32'({out_valid, out_count, out}), 32'({1'b1, 3'd1, 4'b0000}));
`ifdef LOGIC_FLAGS_EN
    chk("flag_zero_set", 32'({out_zero, out_msb}), 32'b10);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
